prio_aging_req_gen: RTL and testbench

Upstream request-conditioning stage for the 3-source priority arbiter. Buffers per-source request pulses in pending counters and presents the arbiter's `req[2:0]` and `prios[8:0]` inputs. Consumes the arbiter's registered `gnt[2:0]`/`valid` to retire requests. Each waiting source's effective priority rises with age, so a low-priority source cannot starve behind a persistently busy high-priority one.

---
 rtl/arb_pkg.sv | 28 ++
 rtl/prio_age_src.sv | 74 +++++++
 rtl/prio_aging_req_gen.sv | 47 ++++
 tb/tb_prio_aging_req_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 3-source priority arbiter: source count, priority width,
// saturating priority add and packing helpers for the 9-bit priority vector.
package arb_pkg;

  localparam int NUM_SRC = 3;
  localparam int PRIO_W  = 3;
  localparam logic [PRIO_W-1:0] PRIO_MAX = 3'd7;

  typedef logic [NUM_SRC*PRIO_W-1:0] prio_vec_t;

  function automatic logic [PRIO_W-1:0] prio_sat_add(input logic [PRIO_W-1:0] base,
                                                     input logic [PRIO_W-1:0] boost);
    logic [PRIO_W:0] sum;
    sum = {1'b0, base} + {1'b0, boost};
    return (sum > {1'b0, PRIO_MAX}) ? PRIO_MAX : sum[PRIO_W-1:0];
  endfunction

  function automatic logic [PRIO_W-1:0] prio_unpack(input prio_vec_t vec, input int idx);
    return vec[idx*PRIO_W +: PRIO_W];
  endfunction

  function automatic prio_vec_t prio_pack(input logic [PRIO_W-1:0] p0,
                                          input logic [PRIO_W-1:0] p1,
                                          input logic [PRIO_W-1:0] p2);
    return {p2, p1, p0};
  endfunction

endpackage

// File: rtl/prio_age_src.sv
// Per-source slice: pending counter, request masking, priority aging (PRIO_AGING_EN).
// Latency: req one cycle after push; full drops pushes (sticky ovf) unless a grant lands together.
module prio_age_src
  import arb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int AGE_PERIOD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              take,
  input  logic              gnt_bit,
  input  logic [PRIO_W-1:0] base,
  output logic              req,
  output logic [PRIO_W-1:0] prio,
  output logic              full,
  output logic              ovf,
  output logic              gnt_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 1 || AGE_PERIOD < 1) begin : g_cfg_err
    $error("prio_age_src: DEPTH and AGE_PERIOD must be >= 1");
  end

  logic [CNT_W-1:0] cnt;

  assign full = (cnt == CNT_W'(DEPTH));
  // The grant seen now retires one request at this edge, so hide it from the arbiter.
  assign req  = (cnt > CNT_W'(gnt_bit));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      ovf     <= 1'b0;
      gnt_err <= 1'b0;
    end else begin
      if (take && cnt == '0) gnt_err <= 1'b1;
      if (push && full && !take) ovf <= 1'b1;
      if (push && !take && !full) cnt <= cnt + 1'b1;
      else if (take && !push && cnt != '0) cnt <= cnt - 1'b1;
    end
  end

`ifdef PRIO_AGING_EN
  localparam int TMR_W = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;

  logic [TMR_W-1:0]  tmr;
  logic [PRIO_W-1:0] boost;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr   <= '0;
      boost <= '0;
    end else if (take || cnt == '0) begin
      tmr   <= '0;
      boost <= '0;
    end else if (tmr == TMR_W'(AGE_PERIOD - 1)) begin
      tmr <= '0;
      // Stop boosting once the effective priority is already at the ceiling.
      if (prio_sat_add(base, boost) < PRIO_MAX) boost <= boost + 1'b1;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end

  assign prio = prio_sat_add(base, boost);
`else
  assign prio = base;
`endif

endmodule

// File: rtl/prio_aging_req_gen.sv
// Request conditioning ahead of the 3-source arbiter; aging enabled by `define PRIO_AGING_EN.
// Latency: req/prios one cycle after push; pushes into a full source are dropped and flagged.
module prio_aging_req_gen
  import arb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int AGE_PERIOD = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         src_push,
  input  logic [NUM_SRC*PRIO_W-1:0]  src_base_prio,
  input  logic [NUM_SRC-1:0]         gnt,
  input  logic                       valid,
  output logic [NUM_SRC-1:0]         req,
  output logic [NUM_SRC*PRIO_W-1:0]  prios,
  output logic [NUM_SRC-1:0]         src_full,
  output logic [NUM_SRC-1:0]         ovf,
  output logic                       gnt_err
);

  logic [PRIO_W-1:0]  prio_s [NUM_SRC];
  logic [NUM_SRC-1:0] err_s;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    prio_age_src #(
      .DEPTH      (DEPTH),
      .AGE_PERIOD (AGE_PERIOD)
    ) u_src (
      .clk     (clk),
      .rst     (rst),
      .push    (src_push[i]),
      .take    (valid && gnt[i]),
      .gnt_bit (gnt[i]),
      .base    (prio_unpack(src_base_prio, i)),
      .req     (req[i]),
      .prio    (prio_s[i]),
      .full    (src_full[i]),
      .ovf     (ovf[i]),
      .gnt_err (err_s[i])
    );
  end

  assign prios   = prio_pack(prio_s[0], prio_s[1], prio_s[2]);
  assign gnt_err = |err_s;

endmodule

// File: tb/tb_prio_aging_req_gen.sv
// Directed bench for prio_aging_req_gen with DEPTH=4, AGE_PERIOD=8; expectations follow PRIO_AGING_EN.
module tb_prio_aging_req_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] src_push, gnt, req, src_full, ovf;
  logic [8:0] src_base_prio, prios;
  logic       valid, gnt_err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  prio_aging_req_gen #(
    .DEPTH      (4),
    .AGE_PERIOD (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .src_push      (src_push),
    .src_base_prio (src_base_prio),
    .gnt           (gnt),
    .valid         (valid),
    .req           (req),
    .prios         (prios),
    .src_full      (src_full),
    .ovf           (ovf),
    .gnt_err       (gnt_err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] p, input logic [2:0] g);
    src_push = p;
    gnt      = g;
    valid    = |g;
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Source2 effective priority (base 2) after n unserved cycles of waiting.
  function automatic logic [2:0] age_exp(input int n);
`ifdef PRIO_AGING_EN
    int v;
    v = 2 + n / 8;
    return (v > 7) ? 3'd7 : 3'(v);
`else
    return 3'd2 + 3'(n * 0);
`endif
  endfunction

  initial begin
    rst           = 1'b0;
    src_push      = '0;
    gnt           = '0;
    valid         = 1'b0;
    src_base_prio = {3'd2, 3'd1, 3'd5};
    #12;
    chk("rst_req",     16'(req),      16'(3'b000));
    chk("rst_full",    16'(src_full), 16'(3'b000));
    chk("rst_ovf",     16'(ovf),      16'(3'b000));
    chk("rst_gnt_err", 16'(gnt_err),  16'(1'b0));
    chk("rst_prios",   16'(prios),    16'(9'b010_001_101));
    cyc();
    rst = 1'b1;

    // Single request on source0, granted two cycles later.
    drive(3'b001, 3'b000);
    cyc(); drive(3'b000, 3'b000);
    chk("t1_req", 16'(req), 16'(3'b001));
    cyc(); drive(3'b000, 3'b001);
    chk("t1_req_masked", 16'(req), 16'(3'b000));
    cyc(); drive(3'b000, 3'b000);
    chk("t1_req_idle", 16'(req), 16'(3'b000));
    chk("t1_gnt_err",  16'(gnt_err), 16'(1'b0));

    // Fill source1, overflow on the fifth push, then drain with four grants.
    drive(3'b010, 3'b000);
    repeat (4) cyc();
    chk("t2_full4", 16'(src_full), 16'(3'b010));
    chk("t2_ovf4",  16'(ovf),      16'(3'b000));
    cyc(); drive(3'b000, 3'b000);
    chk("t2_ovf5",  16'(ovf),      16'(3'b010));
    chk("t2_full5", 16'(src_full), 16'(3'b010));
    for (int k = 1; k <= 4; k++) begin
      drive(3'b000, 3'b010);
      chk("t2_req_gnt", 16'(req[1]), 16'(k < 4));
      cyc();
    end
    drive(3'b000, 3'b000);
    chk("t2_req_drained", 16'(req),      16'(3'b000));
    chk("t2_full_clr",    16'(src_full), 16'(3'b000));
    chk("t2_gnt_err",     16'(gnt_err),  16'(1'b0));

    // Push and grant together on full source0.
    drive(3'b001, 3'b000);
    repeat (4) cyc();
    drive(3'b001, 3'b001);
    chk("t3_full_before", 16'(src_full), 16'(3'b001));
    cyc(); drive(3'b000, 3'b000);
    chk("t3_full_kept", 16'(src_full), 16'(3'b001));
    chk("t3_ovf",       16'(ovf),      16'(3'b010));
    for (int k = 0; k < 4; k++) begin
      drive(3'b000, 3'b001);
      cyc();
    end
    drive(3'b000, 3'b000);
    chk("t3_req_drained", 16'(req), 16'(3'b000));

    // Source2 waits unserved for 100 cycles; its priority ages and saturates.
    drive(3'b100, 3'b000);
    cyc(); drive(3'b000, 3'b000);
    for (int i = 0; i < 100; i++) begin
      chk("t4_prios", 16'({age_exp(i), 3'd1, 3'd5}), 16'(prios));
      cyc();
    end
    chk("t4_req_pending", 16'(req), 16'(3'b100));
    src_base_prio = {3'd6, 3'd1, 3'd5};
    #1;
`ifdef PRIO_AGING_EN
    chk("t4_base6", 16'(prios[8:6]), 16'(3'd7));
`else
    chk("t4_base6", 16'(prios[8:6]), 16'(3'd6));
`endif
    src_base_prio = {3'd0, 3'd1, 3'd5};
    #1;
`ifdef PRIO_AGING_EN
    chk("t4_base0", 16'(prios[8:6]), 16'(3'd5));
`else
    chk("t4_base0", 16'(prios[8:6]), 16'(3'd0));
`endif
    drive(3'b000, 3'b100);
    chk("t4_req_masked", 16'(req), 16'(3'b000));
    cyc(); drive(3'b000, 3'b000);
    chk("t4_prios_clr", 16'(prios),   16'(9'b000_001_101));
    chk("t4_gnt_err",   16'(gnt_err), 16'(1'b0));

    // Grant to an empty source2 sets a sticky error.
    drive(3'b000, 3'b100);
    cyc(); drive(3'b000, 3'b000);
    chk("t5_gnt_err_set", 16'(gnt_err), 16'(1'b1));
    repeat (3) cyc();
    chk("t5_gnt_err_sticky", 16'(gnt_err), 16'(1'b1));

    // Reset mid-operation discards pending work; stale grant afterwards is an error.
    drive(3'b001, 3'b000);
    cyc(); drive(3'b000, 3'b000);
    chk("t6_req_pending", 16'(req), 16'(3'b001));
    rst = 1'b0;
    #1;
    chk("t6_rst_req",     16'(req),     16'(3'b000));
    chk("t6_rst_gnt_err", 16'(gnt_err), 16'(1'b0));
    chk("t6_rst_ovf",     16'(ovf),     16'(3'b000));
    cyc();
    rst = 1'b1;
    drive(3'b000, 3'b001);
    cyc(); drive(3'b000, 3'b000);
    chk("t6_stale_gnt", 16'(gnt_err), 16'(1'b1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
